mdu_param: RTL and testbench

- Parametrised multiply/divide unit for the E stage of the pipelined core. It succeeds the fixed 32-bit MDU.
- Adds configurable operand width and per-class latency, MADD/MADDU/MSUB/MSUBU accumulate ops, and a divide-by-zero flag.
- Owns the HI/LO registers. The stall unit combines `busy` with an MDU-class op decoded in D.

---
 rtl/mdu_param.sv | 161 ++++++++++++++++
 tb/tb_mdu_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit for the E stage. Owns HI/LO, runs long ops
// (multiply, accumulate, divide) over a fixed per-class number of busy cycles,
// and flags divide-by-zero with a one-cycle pulse after the op completes.
module mdu_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMadd  = 4'd5;
    localparam logic [3:0] OpMaddu = 4'd6;
    localparam logic [3:0] OpMsub  = 4'd7;
    localparam logic [3:0] OpMsubu = 4'd8;
    localparam logic [3:0] OpMfhi  = 4'd9;
    localparam logic [3:0] OpMflo  = 4'd10;
    localparam logic [3:0] OpMthi  = 4'd11;
    localparam logic [3:0] OpMtlo  = 4'd12;

    localparam int unsigned MaxCyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]       shi_q, shi_d, slo_q, slo_d;
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                   dz_pend_q, dz_pend_d;
    logic                   div_zero_q, div_zero_d;

    logic                   is_signed, is_mul, is_div;
    logic [2*WIDTH-1:0]     acc, ext_a, ext_b, prod, staged;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Datapath: one shared multiplier and one shared magnitude divider.
    always_comb begin
        is_signed = (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
        is_mul    = (op == OpMult) || (op == OpMultu) || (op == OpMadd) ||
                    (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
        is_div    = (op == OpDiv) || (op == OpDivu);
        acc       = {hi_q, lo_q};
        // Sign/zero-extending to 2*WIDTH makes the low 2*WIDTH product bits exact
        ext_a     = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
        ext_b     = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
        prod      = ext_a * ext_b;
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        // MIN/-1 falls out naturally: |MIN| negated wraps back to MIN, remainder 0
        quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem       = a_neg ? -r_mag : r_mag;
        staged    = acc;
        if (op == OpMult || op == OpMultu) begin
            staged = prod;
        end else if (op == OpMadd || op == OpMaddu) begin
            staged = acc + prod;
        end else if (op == OpMsub || op == OpMsubu) begin
            staged = acc - prod;
        end else if (is_div && (b != '0)) begin
            staged = {rem, quo};
        end
    end

    // Next-state logic for the IDLE/RUN sequencer and HI/LO moves.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shi_d      = shi_q;
        slo_d      = slo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dz_pend_d  = dz_pend_q;
        div_zero_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul || is_div) begin
                        {shi_d, slo_d} = staged;
                        cnt_d          = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        dz_pend_d      = is_div && (b == '0);
                        state_d        = StRun;
                    end else if (op == OpMthi) begin
                        hi_d = a;
                    end else if (op == OpMtlo) begin
                        lo_d = a;
                    end
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    hi_d       = shi_q;
                    lo_d       = slo_q;
                    div_zero_d = dz_pend_q;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shi_q      <= '0;
            slo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dz_pend_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shi_q      <= shi_d;
            slo_q      <= slo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dz_pend_q  <= dz_pend_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Outputs: MFHI/MFLO read path is purely combinational on op.
    always_comb begin
        result = '0;
        if (op == OpMfhi) begin
            result = hi_q;
        end else if (op == OpMflo) begin
            result = lo_q;
        end
        busy     = (state_q == StRun);
        hi       = hi_q;
        lo       = lo_q;
        div_zero = div_zero_q;
    end

endmodule

// File: tb/tb_mdu_param.sv
// Bench for mdu_param: directed vector table, reset abort, back-pressure
// injection, and random long ops against an arithmetic reference model.
module tb_mdu_param;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MFHI  = 4'd9;
    localparam logic [3:0] OP_MFLO  = 4'd10;
    localparam logic [3:0] OP_MTHI  = 4'd11;
    localparam logic [3:0] OP_MTLO  = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] result, hi, lo;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .result(result), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        pre;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: {dz, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        int          xi = x;
        int          yi = y;
        longint      ps = longint'(xi) * longint'(yi);
        logic [63:0] pu = {32'd0, x} * {32'd0, y};
        logic [63:0] accv = {h, l};
        logic [63:0] r = accv;
        logic        dz = 1'b0;
        case (o)
            4'd1: r = ps;
            4'd2: r = pu;
            4'd5: r = accv + ps;
            4'd6: r = accv + pu;
            4'd7: r = accv - ps;
            4'd8: r = accv - pu;
            4'd3: begin
                if (y == 0) dz = 1'b1;
                else if (x == 32'h8000_0000 && yi == -1) r = {32'd0, 32'h8000_0000};
                else r = {32'(xi % yi), 32'(xi / yi)};
            end
            4'd4: begin
                if (y == 0) dz = 1'b1;
                else r = {x % y, x / y};
            end
            default: r = accv;
        endcase
        return {dz, r};
    endfunction

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; a = v; b = '0;
        @(negedge clk);
        start = 1'b0;
        op = (o == OP_MTHI) ? OP_MFHI : OP_MFLO;
        #1;
        check((o == OP_MTHI) ? "mfhi_after_mthi" : "mflo_after_mtlo", {32'd0, result}, {32'd0, v});
        check("move_no_busy", {63'd0, busy}, 64'd0);
        if (o == OP_MTHI) hi_m = v; else lo_m = v;
        op = OP_NONE;
    endtask

    task automatic long_op(input string name, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz, input bit inject);
        int          n = 0;
        logic        disturbed = 1'b0;
        logic [63:0] old = {hi_m, lo_m};
        int          want = (o == OP_DIV || o == OP_DIVU) ? 10 : 5;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        while (busy && n < 40) begin
            n++;
            if ({hi, lo} !== old || div_zero !== 1'b0) disturbed = 1'b1;
            if (inject && n == 2) begin
                start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; op = OP_NONE;
            end
            @(negedge clk);
        end
        start = 1'b0; op = OP_NONE;
        check({name, "_busy_cycles"}, 64'(n), 64'(want));
        check({name, "_held_while_busy"}, {63'd0, disturbed}, 64'd0);
        check({name, "_hilo"}, {hi, lo}, {eh, el});
        check({name, "_dz_pulse"}, {63'd0, div_zero}, {63'd0, edz});
        @(negedge clk);
        check({name, "_dz_clear"}, {63'd0, div_zero}, 64'd0);
        hi_m = eh; lo_m = el;
    endtask

    initial begin
        logic [64:0] m;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b1, 32'h0, 32'h0,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{OP_DIVU,  32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 32'd2, 32'd14, 1'b0};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0, 32'h0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0,
                    32'h0, 32'h8000_0000, 1'b0};
        vecs[4] = '{OP_DIV,   32'd5, 32'd0, 1'b1, 32'h11, 32'h22, 32'h11, 32'h22, 1'b1};
        vecs[5] = '{OP_MADDU, 32'd1, 32'd1, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        vecs[6] = '{OP_MSUB,  32'd1, 32'd1, 1'b0, 32'h0, 32'h0, 32'd0, 32'hFFFF_FFFF, 1'b0};
        // {0,FFFFFFFF} - (-1*1) = 0x1_00000000
        vecs[7] = '{OP_MSUB,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 32'h0, 32'd1, 32'd0, 1'b0};
        vecs[8] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h5, 32'h6,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[9] = '{OP_MSUBU, 32'd2, 32'd3, 1'b1, 32'h0, 32'h0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};

        reset = 1'b0; start = 1'b0; op = OP_NONE; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_dz", {63'd0, div_zero}, 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].pre) begin
                mt(OP_MTHI, vecs[i].pre_hi);
                mt(OP_MTLO, vecs[i].pre_lo);
            end
            long_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, 1'b0);
        end

        // result is zero for non-move ops and ignores start
        op = OP_MULT; #1;
        check("result_nonmove", {32'd0, result}, 64'd0);
        op = OP_MFLO; #1;
        check("result_mflo_nostart", {32'd0, result}, {32'd0, lo_m});

        // Abort: reset asserted mid-divide clears everything asynchronously
        mt(OP_MTHI, 32'h55);
        mt(OP_MTLO, 32'h66);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd2;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        check("abort_stays_idle", {63'd0, busy}, 64'd0);
        long_op("post_abort_mult", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);

        // Reserved op with start changes nothing
        @(negedge clk);
        start = 1'b1; op = 4'd14; a = 32'hABCD;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        check("reserved_op_busy", {63'd0, busy}, 64'd0);
        check("reserved_op_hilo", {hi, lo}, {hi_m, lo_m});

        // Random long ops and moves against the model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            if (sel == 0) begin
                mt(OP_MTHI, ra);
            end else if (sel == 1) begin
                mt(OP_MTLO, ra);
            end else begin
                ro = 4'($urandom_range(1, 8));
                if ($urandom_range(0, 7) == 0) rb = '0;
                if ($urandom_range(0, 7) == 0) begin
                    ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
                end
                if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
                m = model(ro, ra, rb, hi_m, lo_m);
                long_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb,
                        m[63:32], m[31:0], m[64], (i % 7) == 3);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
